// File: rtl/fifo_pkg.sv
// Shared types and elaboration helpers for the single-clock FWFT FIFO.
package fifo_pkg;

   typedef enum logic [1:0] {
      MEM_AUTO,
      MEM_DISTRIBUTED,
      MEM_BLOCK
   } mem_type_e;

   function automatic int addr_w(input int depth);
      return $clog2(depth);
   endfunction

   function automatic bit params_legal(input int depth, input int wdw, input int rdw,
                                       input int stages);
      bit ok;
      ok = (depth >= 16) && (depth <= 65536) && ((depth & (depth - 1)) == 0);
      ok = ok && (wdw >= 1) && (wdw == rdw);
      ok = ok && (stages >= 2) && (stages <= 8);
      return ok;
   endfunction

   // Unknown strings fall back to letting the synthesis tool choose.
   function automatic mem_type_e mem_type_from_str(input string s);
      mem_type_e t;
      t = MEM_AUTO;
      if (s == "block") t = MEM_BLOCK;
      else if (s == "distributed") t = MEM_DISTRIBUTED;
      return t;
   endfunction

endpackage

// File: rtl/fifo_fwft_sc_if.sv
// Write/read bus of the FWFT FIFO. FIFO_ADV_FLAGS_EN adds overflow, underflow and data_count.
interface fifo_fwft_sc_if #(
   parameter int DW = 32
`ifdef FIFO_ADV_FLAGS_EN
   , parameter int AW = 5
`endif
);
   // Handshake: a push is taken on a rising edge when wr_en && !full && !wr_rst_busy; a pop
   // is taken when rd_en && !empty && !rd_rst_busy. !empty is the valid for dout, rd_en is
   // its ready, and the word on dout is consumed by that same edge.
   logic [DW-1:0] din;
   logic          wr_en;
   logic          full;
   logic          wr_rst_busy;
   logic [DW-1:0] dout;
   logic          rd_en;
   logic          empty;
   logic          rd_rst_busy;
`ifdef FIFO_ADV_FLAGS_EN
   logic          overflow;
   logic          underflow;
   logic [AW:0]   data_count;
`endif

   modport master (
      output din, wr_en, rd_en,
      input  full, wr_rst_busy, dout, empty, rd_rst_busy
`ifdef FIFO_ADV_FLAGS_EN
      , input overflow, underflow, data_count
`endif
   );

   modport slave (
      input  din, wr_en, rd_en,
      output full, wr_rst_busy, dout, empty, rd_rst_busy
`ifdef FIFO_ADV_FLAGS_EN
      , output overflow, underflow, data_count
`endif
   );

endinterface

// File: rtl/fifo_sdp_ram.sv
// Simple dual-port RAM with one write port and one registered read port. The read register
// is the FWFT head stage: it resets to RST_VAL and holds whenever re is low.
module fifo_sdp_ram
   import fifo_pkg::*;
#(
   parameter int            DEPTH    = 32,
   parameter int            DW       = 32,
   parameter int            AW       = addr_w(DEPTH),
   parameter mem_type_e     MEM_TYPE = MEM_AUTO,
   parameter logic [DW-1:0] RST_VAL  = '0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] rd_word;

   if (MEM_TYPE == MEM_BLOCK) begin : g_block
      (* ram_style = "block" *) logic [DW-1:0] mem [DEPTH];
      always_ff @(posedge clk) begin
         if (we) mem[waddr] <= wdata;
      end
      assign rd_word = mem[raddr];
   end else if (MEM_TYPE == MEM_DISTRIBUTED) begin : g_dist
      (* ram_style = "distributed" *) logic [DW-1:0] mem [DEPTH];
      always_ff @(posedge clk) begin
         if (we) mem[waddr] <= wdata;
      end
      assign rd_word = mem[raddr];
   end else begin : g_auto
      (* ram_style = "auto" *) logic [DW-1:0] mem [DEPTH];
      always_ff @(posedge clk) begin
         if (we) mem[waddr] <= wdata;
      end
      assign rd_word = mem[raddr];
   end

   // The RAM contents are never cleared; only the output register is.
   always_ff @(posedge clk) begin
      if (rst) rdata <= RST_VAL;
      else if (re) rdata <= rd_word;
   end

endmodule

// File: rtl/fifo_fwft_sc.sv
// Single-clock first-word-fall-through FIFO with vendor-style reset-busy flags.
// Defining FIFO_ADV_FLAGS_EN adds the overflow, underflow and data_count outputs.
module fifo_fwft_sc
   import fifo_pkg::*;
#(
   parameter int                         FIFO_WRITE_DEPTH = 32,
   parameter int                         WRITE_DATA_WIDTH = 32,
   parameter int                         READ_DATA_WIDTH  = 32,
   parameter string                      FIFO_MEMORY_TYPE = "auto",
   parameter logic [READ_DATA_WIDTH-1:0] DOUT_RESET_VALUE = '0,
   parameter int                         CDC_SYNC_STAGES  = 2
) (
   input logic           clk,
   input logic           rst,
   fifo_fwft_sc_if.slave bus
);

   localparam int              AW        = addr_w(FIFO_WRITE_DEPTH);
   localparam int              DW        = WRITE_DATA_WIDTH;
   localparam logic [AW:0]     DEPTH_CNT = (AW + 1)'(FIFO_WRITE_DEPTH);
   localparam mem_type_e       MEM_TYPE  = mem_type_from_str(FIFO_MEMORY_TYPE);

   if (!params_legal(FIFO_WRITE_DEPTH, WRITE_DATA_WIDTH, READ_DATA_WIDTH,
                     CDC_SYNC_STAGES)) begin : g_bad_params
      $fatal(1, "fifo_fwft_sc: illegal parameter combination");
   end

   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic [AW:0]   count_next;
   logic [AW:0]   ram_cnt;
   logic          head_valid;
   logic          head_valid_next;
   logic          push_ok;
   logic          pop_ok;
   logic          ram_rd;
   logic [3:0]    busy_cnt;
   logic          busy_q;
   logic          busy_next;
   logic          full_q;

   // count covers RAM words plus the head register; the RAM refills the head whenever the
   // head is free or being popped, which keeps back-to-back pops gap-free.
   always_comb begin
      push_ok         = bus.wr_en & ~full_q & ~busy_q;
      pop_ok          = bus.rd_en & head_valid & ~busy_q;
      ram_cnt         = count - {{AW{1'b0}}, head_valid};
      ram_rd          = (ram_cnt != '0) & (~head_valid | pop_ok);
      head_valid_next = (ram_cnt != '0) | (head_valid & ~pop_ok);
      count_next      = count + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop_ok};
      busy_next       = (busy_cnt != '0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         head_valid <= 1'b0;
         busy_cnt   <= 4'(CDC_SYNC_STAGES);
         busy_q     <= 1'b1;
         full_q     <= 1'b1;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (ram_rd) rd_ptr <= rd_ptr + 1'b1;
         count      <= count_next;
         head_valid <= head_valid_next;
         if (busy_next) busy_cnt <= busy_cnt - 1'b1;
         busy_q     <= busy_next;
         // Held high through reset-busy so it falls together with wr_rst_busy.
         full_q     <= busy_next | (count_next == DEPTH_CNT);
      end
   end

   fifo_sdp_ram #(
      .DEPTH    (FIFO_WRITE_DEPTH),
      .DW       (DW),
      .AW       (AW),
      .MEM_TYPE (MEM_TYPE),
      .RST_VAL  (DOUT_RESET_VALUE)
   ) u_ram (
      .clk   (clk),
      .rst   (rst),
      .we    (push_ok),
      .waddr (wr_ptr),
      .wdata (bus.din),
      .re    (ram_rd),
      .raddr (rd_ptr),
      .rdata (bus.dout)
   );

   assign bus.full        = full_q;
   assign bus.empty       = ~head_valid;
   assign bus.wr_rst_busy = busy_q;
   assign bus.rd_rst_busy = busy_q;

`ifdef FIFO_ADV_FLAGS_EN
   logic overflow_q;
   logic underflow_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         overflow_q  <= bus.wr_en & full_q;
         underflow_q <= bus.rd_en & ~head_valid;
      end
   end

   assign bus.overflow   = overflow_q;
   assign bus.underflow  = underflow_q;
   assign bus.data_count = count;
`endif

endmodule

// File: tb/tb_fifo_fwft_sc.sv
// Bench for fifo_fwft_sc (DEPTH=16, 8-bit): vector table, corner sequences and random traffic
// against a queue model. Extra output checks are compiled when FIFO_ADV_FLAGS_EN is defined.
module tb_fifo_fwft_sc;

   localparam int DEPTH = 16;
   localparam int W     = 8;
   localparam int CDC   = 2;
`ifdef FIFO_ADV_FLAGS_EN
   localparam int AW    = 4;
`endif

   logic clk;
   logic rst;

`ifdef FIFO_ADV_FLAGS_EN
   fifo_fwft_sc_if #(.DW(W), .AW(AW)) bus ();
`else
   fifo_fwft_sc_if #(.DW(W)) bus ();
`endif

   fifo_fwft_sc #(
      .FIFO_WRITE_DEPTH (DEPTH),
      .WRITE_DATA_WIDTH (W),
      .READ_DATA_WIDTH  (W),
      .FIFO_MEMORY_TYPE ("block"),
      .DOUT_RESET_VALUE (8'h00),
      .CDC_SYNC_STAGES  (CDC)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded its time limit");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard / reference model ----------------
   logic [W-1:0] exp_q[$];
   bit           m_empty;
   bit           m_full;
   bit           m_busy;
   bit           m_ovf;
   bit           m_udf;
   logic [W-1:0] m_dout;
   int           rel_edges;
   int           n_checks;
   int           n_errors;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_outputs();
      chk("empty", 32'(bus.empty), 32'(m_empty));
      chk("full", 32'(bus.full), 32'(m_full));
      chk("wr_rst_busy", 32'(bus.wr_rst_busy), 32'(m_busy));
      chk("rd_rst_busy", 32'(bus.rd_rst_busy), 32'(m_busy));
      chk("dout", 32'(bus.dout), 32'(m_dout));
`ifdef FIFO_ADV_FLAGS_EN
      chk("overflow", 32'(bus.overflow), 32'(m_ovf));
      chk("underflow", 32'(bus.underflow), 32'(m_udf));
      chk("data_count", 32'(bus.data_count), 32'(exp_q.size()));
`endif
   endtask

   // ---------------- driver tasks ----------------
   task automatic do_reset();
      rst       = 1'b1;
      bus.wr_en = 1'b0;
      bus.rd_en = 1'b0;
      bus.din   = '0;
      repeat (3) @(posedge clk);
      #1;
      exp_q.delete();
      m_empty   = 1'b1;
      m_full    = 1'b1;
      m_busy    = 1'b1;
      m_ovf     = 1'b0;
      m_udf     = 1'b0;
      m_dout    = '0;
      rel_edges = 0;
      check_outputs();
      rst = 1'b0;
   endtask

   // One clock of traffic. A word is visible after an edge exactly when it was already
   // stored before that edge and was not the one popped on it.
   task automatic step(input bit wr, input bit rd, input logic [W-1:0] d);
      bit push_ok;
      bit pop_ok;
      int occ_before;
      bus.wr_en  = wr;
      bus.rd_en  = rd;
      bus.din    = d;
      push_ok    = wr && !m_full && !m_busy;
      pop_ok     = rd && !m_empty && !m_busy;
      m_ovf      = wr && m_full;
      m_udf      = rd && m_empty;
      occ_before = exp_q.size();
      @(posedge clk);
      if (pop_ok) void'(exp_q.pop_front());
      if (push_ok) exp_q.push_back(d);
      if (rel_edges <= CDC) rel_edges++;
      m_busy  = (rel_edges <= CDC);
      m_empty = (occ_before - int'(pop_ok)) <= 0;
      m_full  = m_busy || (exp_q.size() == DEPTH);
      if (!m_empty) m_dout = exp_q[0];
      #1;
      check_outputs();
      bus.wr_en = 1'b0;
      bus.rd_en = 1'b0;
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      bit           wr;
      bit           rd;
      logic [W-1:0] din;
      bit           e_empty;
      bit           e_full;
      logic [W-1:0] e_dout;
   } vec_t;

   vec_t vecs[12];

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst      = 1'b1;

      vecs[0]  = '{1'b1, 1'b0, 8'hA5, 1'b1, 1'b0, 8'h00};
      vecs[1]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'hA5};
      vecs[2]  = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 8'hA5};
      vecs[3]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'hA5};
      vecs[4]  = '{1'b1, 1'b0, 8'h11, 1'b1, 1'b0, 8'hA5};
      vecs[5]  = '{1'b1, 1'b0, 8'h22, 1'b0, 1'b0, 8'h11};
      vecs[6]  = '{1'b1, 1'b1, 8'h33, 1'b0, 1'b0, 8'h22};
      vecs[7]  = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'h33};
      vecs[8]  = '{1'b1, 1'b1, 8'h44, 1'b1, 1'b0, 8'h33};
      vecs[9]  = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'h44};
      vecs[10] = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 8'h44};
      vecs[11] = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 8'h44};

      // Reset and busy stretch; a push attempted while busy must be ignored.
      do_reset();
      step(1'b1, 1'b0, 8'hEE);
      chk("rel1_busy", 32'(bus.wr_rst_busy), 32'd1);
      chk("rel1_full", 32'(bus.full), 32'd1);
      step(1'b0, 1'b0, 8'h00);
      chk("rel2_busy", 32'(bus.rd_rst_busy), 32'd1);
      chk("rel2_full", 32'(bus.full), 32'd1);
      step(1'b0, 1'b0, 8'h00);
      chk("rel3_busy", 32'(bus.wr_rst_busy), 32'd0);
      chk("rel3_full", 32'(bus.full), 32'd0);
      chk("rel3_empty", 32'(bus.empty), 32'd1);

      // Latency and hand-off vectors.
      for (int i = 0; i < 12; i++) begin
         step(vecs[i].wr, vecs[i].rd, vecs[i].din);
         chk("vec_empty", 32'(bus.empty), 32'(vecs[i].e_empty));
         chk("vec_full", 32'(bus.full), 32'(vecs[i].e_full));
         chk("vec_dout", 32'(bus.dout), 32'(vecs[i].e_dout));
      end
`ifdef FIFO_ADV_FLAGS_EN
      chk("underflow_pulse", 32'(bus.underflow), 32'd1);
      step(1'b0, 1'b0, 8'h00);
      chk("underflow_clear", 32'(bus.underflow), 32'd0);
`endif

      // Fill to full, rejected push, drain in order.
      for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, W'(i));
      chk("fill_full", 32'(bus.full), 32'd1);
      step(1'b1, 1'b0, 8'h99);
      chk("fill_full_hold", 32'(bus.full), 32'd1);
`ifdef FIFO_ADV_FLAGS_EN
      chk("overflow_pulse", 32'(bus.overflow), 32'd1);
`endif
      for (int i = 0; i < DEPTH; i++) begin
         chk("drain_dout", 32'(bus.dout), 32'(i));
         step(1'b0, 1'b1, 8'h00);
      end
      chk("drain_empty", 32'(bus.empty), 32'd1);

      // Simultaneous push and pop while full: pop wins, push dropped.
      for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, W'($urandom));
      step(1'b1, 1'b1, 8'h77);
      chk("simul_full_clear", 32'(bus.full), 32'd0);
`ifdef FIFO_ADV_FLAGS_EN
      chk("simul_count15", 32'(bus.data_count), 32'd15);
`endif
      for (int i = 0; i < DEPTH + 2 && exp_q.size() > 0; i++) step(1'b0, 1'b1, 8'h00);
      chk("simul_drained", 32'(bus.empty), 32'd1);

      // Simultaneous push and pop at 8 words: occupancy constant, order kept.
      for (int i = 0; i < 8; i++) step(1'b1, 1'b0, W'($urandom));
      for (int i = 0; i < 6; i++) step(1'b1, 1'b1, W'($urandom));
      chk("mid_empty", 32'(bus.empty), 32'd0);
`ifdef FIFO_ADV_FLAGS_EN
      chk("mid_count8", 32'(bus.data_count), 32'd8);
`endif
      for (int i = 0; i < DEPTH + 2 && exp_q.size() > 0; i++) step(1'b0, 1'b1, 8'h00);

      // Random traffic, write-heavy then read-heavy, wrapping the pointers several times.
      for (int i = 0; i < 200; i++) begin
         bit w;
         bit r;
         if ((i / 50) % 2 == 0) begin
            w = ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 1) != 0);
         end else begin
            w = ($urandom_range(0, 1) != 0);
            r = ($urandom_range(0, 3) != 0);
         end
         step(w, r, W'($urandom));
      end

      // Reset with data stored discards it.
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, W'($urandom));
      do_reset();
      for (int i = 0; i < CDC + 1; i++) step(1'b0, 1'b0, 8'h00);
      chk("rst_mid_empty", 32'(bus.empty), 32'd1);
      step(1'b1, 1'b0, 8'h5A);
      step(1'b0, 1'b0, 8'h00);
      chk("rst_mid_dout", 32'(bus.dout), 32'h5A);
      step(1'b0, 1'b1, 8'h00);
      chk("rst_mid_final_empty", 32'(bus.empty), 32'd1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
